// File: rtl/regfile_sequencer.sv
// Initiator sequencer for the 8x8 register file: READ -> EXEC -> WRITE per instruction.
// Optional macro REGSEQ_RETIRE_CNT_EN adds a 16-bit retire_cnt output.
module regfile_sequencer #(
   parameter int unsigned W  = 8,
   parameter int unsigned AW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [2:0]    opcode,
   input  logic [AW-1:0] dst,
   input  logic [AW-1:0] src_a,
   input  logic [AW-1:0] src_b,
   input  logic [W-1:0]  imm,
   output logic [AW-1:0] SA,
   output logic [AW-1:0] SB,
   input  logic [W-1:0]  Adata,
   input  logic [W-1:0]  Bdata,
   output logic [AW-1:0] DS,
   output logic          Load,
   output logic [W-1:0]  Ddata,
   output logic          done,
   output logic          carry,
   output logic          zero
`ifdef REGSEQ_RETIRE_CNT_EN
   ,
   output logic [15:0]   retire_cnt
`endif
);

   localparam logic [2:0] OP_LDI = 3'd0;
   localparam logic [2:0] OP_MOV = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_XOR = 3'd6;
   localparam logic [2:0] OP_NOP = 3'd7;

   typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

   state_t          state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic [AW-1:0]   dst_q, dst_d;
   logic [W-1:0]    imm_q, imm_d;
   logic            ready_d, load_d, done_d, carry_d, zero_d;
   logic [AW-1:0]   sa_d, sb_d, ds_d;
   logic [W-1:0]    ddata_d;

   logic [W:0]      sum_c, diff_c;
   logic [W-1:0]    alu_res_c;
   logic            alu_cout_c;

   // ALU on the live read data; diff_c[W] is the borrow out
   always_comb begin
      sum_c      = {1'b0, Adata} + {1'b0, Bdata};
      diff_c     = {1'b0, Adata} - {1'b0, Bdata};
      alu_res_c  = '0;
      alu_cout_c = 1'b0;
      case (op_q)
         OP_LDI: alu_res_c = imm_q;
         OP_MOV: alu_res_c = Adata;
         OP_ADD: begin alu_res_c = sum_c[W-1:0];  alu_cout_c = sum_c[W];  end
         OP_SUB: begin alu_res_c = diff_c[W-1:0]; alu_cout_c = diff_c[W]; end
         OP_AND: alu_res_c = Adata & Bdata;
         OP_OR:  alu_res_c = Adata | Bdata;
         OP_XOR: alu_res_c = Adata ^ Bdata;
         default: alu_res_c = '0;
      endcase
   end

   // Next state and next values of every registered output
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      dst_d   = dst_q;
      imm_d   = imm_q;
      ready_d = instr_ready;
      sa_d    = SA;
      sb_d    = SB;
      ds_d    = DS;
      ddata_d = Ddata;
      load_d  = 1'b0;
      done_d  = 1'b0;
      carry_d = carry;
      zero_d  = zero;
      case (state_q)
         IDLE: begin
            if (instr_valid && instr_ready) begin
               op_d    = opcode;
               dst_d   = dst;
               imm_d   = imm;
               sa_d    = src_a;
               sb_d    = src_b;
               ready_d = 1'b0;
               state_d = READ;
            end
         end
         READ: state_d = EXEC;
         EXEC: begin
            state_d = WRITE;
            done_d  = 1'b1;
            if (op_q != OP_NOP) begin
               load_d  = 1'b1;
               ds_d    = dst_q;
               ddata_d = alu_res_c;
               zero_d  = (alu_res_c == '0);
               if (op_q == OP_ADD || op_q == OP_SUB) carry_d = alu_cout_c;
            end
         end
         WRITE: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= '0;
         dst_q       <= '0;
         imm_q       <= '0;
         instr_ready <= 1'b1;
         SA          <= '0;
         SB          <= '0;
         DS          <= '0;
         Ddata       <= '0;
         Load        <= 1'b0;
         done        <= 1'b0;
         carry       <= 1'b0;
         zero        <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         dst_q       <= dst_d;
         imm_q       <= imm_d;
         instr_ready <= ready_d;
         SA          <= sa_d;
         SB          <= sb_d;
         DS          <= ds_d;
         Ddata       <= ddata_d;
         Load        <= load_d;
         done        <= done_d;
         carry       <= carry_d;
         zero        <= zero_d;
      end
   end

`ifdef REGSEQ_RETIRE_CNT_EN
   // Counts alongside the done pulse so it is visible in the same cycle
   always_ff @(posedge clk) begin
      if (rst)         retire_cnt <= '0;
      else if (done_d) retire_cnt <= retire_cnt + 16'd1;
   end
`endif

endmodule
